// File: rtl/dot8_row_collector.sv
// Row collector for the 8-lane dot-product pipeline: sums CHUNKS partial products
// per matrix row, tags each row with its index and a last-row flag, and queues it.
module dot8_row_collector #(
    parameter int DWIDTH   = 32,
    parameter int OWIDTH   = 32,
    parameter int CHUNKS   = 4,
    parameter int NUM_ROWS = 4,
    parameter int DEPTH    = 4,
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ivalid,
    input  logic signed [DWIDTH-1:0] idata,
    output logic signed [OWIDTH-1:0] odata,
    output logic [ROW_W-1:0]         orow,
    output logic                     olast,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);

    localparam int CC_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [OWIDTH-1:0] data;
        logic [ROW_W-1:0]  row;
        logic              last;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            head;
    logic [CC_W-1:0]   ccnt_q, ccnt_d;
    logic [OWIDTH-1:0] acc_q, acc_d;
    logic [ROW_W-1:0]  rcnt_q, rcnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [OWIDTH-1:0] idata_ext;
    logic [OWIDTH-1:0] sum;
    logic              last_beat;
    logic              full;
    logic              pop;
    logic              do_write;
    logic              row_is_last;

    // Narrow inputs are sign-extended; wide inputs keep only their low OWIDTH bits.
    if (DWIDTH >= OWIDTH) begin : g_trunc
        assign idata_ext = idata[OWIDTH-1:0];
    end else begin : g_sext
        assign idata_ext = {{(OWIDTH-DWIDTH){idata[DWIDTH-1]}}, idata};
    end

    assign last_beat   = ivalid && (ccnt_q == CC_W'(CHUNKS-1));
    assign sum         = ((ccnt_q == '0) ? '0 : acc_q) + idata_ext;
    assign row_is_last = (rcnt_q == ROW_W'(NUM_ROWS-1));
    assign full        = (count_q == CNT_W'(DEPTH));
    assign ovalid      = (count_q != '0);
    assign pop         = ovalid && oready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign do_write    = last_beat && (!full || pop);

    // NOTE: combinational next-state logic uses blocking assignments, with every
    // output defaulted first so no latch can be inferred.
    always_comb begin
        ccnt_d     = ccnt_q;
        acc_d      = acc_q;
        rcnt_d     = rcnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (ivalid) begin
            acc_d  = sum;
            ccnt_d = last_beat ? '0 : ccnt_q + 1'b1;
        end
        // The row counter advances even when the row is dropped.
        if (last_beat) begin
            rcnt_d = row_is_last ? '0 : rcnt_q + 1'b1;
        end
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_write && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_write) begin
            count_d = count_q - 1'b1;
        end
        if (last_beat && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccnt_q     <= '0;
            acc_q      <= '0;
            rcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ccnt_q     <= ccnt_d;
            acc_q      <= acc_d;
            rcnt_q     <= rcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; entries are only read
    // while count marks them occupied, so resetting would only cost flops.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= '{data: sum, row: rcnt_q, last: row_is_last};
        end
    end

    // Head fields are forced to zero while empty so reset presents clean outputs.
    assign head     = mem_q[rd_ptr_q];
    assign odata    = ovalid ? head.data : '0;
    assign orow     = ovalid ? head.row  : '0;
    assign olast    = ovalid && head.last;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dot8_row_collector.sv
// Self-checking bench for dot8_row_collector (default parameters): a scoreboard queue
// holds expected rows, compared whenever the DUT hands a row downstream.
module tb_dot8_row_collector;

    logic        clk;
    logic        rst;
    logic        ivalid;
    logic [31:0] idata;
    logic [31:0] odata;
    logic [1:0]  orow;
    logic        olast;
    logic        ovalid;
    logic        oready;
    logic [2:0]  count;
    logic        overflow;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  row;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    dot8_row_collector dut (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .idata    (idata),
        .odata    (odata),
        .orow     (orow),
        .olast    (olast),
        .ovalid   (ovalid),
        .oready   (oready),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [31:0] d, input int r, input logic l);
        exp_t e;
        e.data = d;
        e.row  = 2'(r);
        e.last = l;
        sb.push_back(e);
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic beat(input logic [31:0] v);
        ivalid = 1'b1;
        idata  = v;
        @(posedge clk); #1;
        ivalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Scoreboard: every accepted head entry is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ovalid && oready) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("spurious_row", ovalid, 0);
            end else begin
                e = sb.pop_front();
                check("odata", odata, e.data);
                check("orow", orow, e.row);
                check("olast", olast, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        oready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", ovalid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_olast", olast, 0);
        check("rst_orow", orow, 0);
        check("rst_odata", odata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic row with one-cycle latency and a single-cycle output.
        push_exp(32'd10, 0, 1'b0);
        beat(1); beat(2); beat(3); beat(4);
        @(negedge clk);
        check("basic_ovalid_hi", ovalid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("basic_ovalid_lo", ovalid, 0);
        @(posedge clk); #1;

        // Gapped input.
        push_exp(32'd10, 1, 1'b0);
        beat(1); idle(1); beat(2); idle(2); beat(3); idle(3); beat(4);
        @(negedge clk);
        check("gap_ovalid_hi", ovalid, 1);
        @(posedge clk); #1;
        wait_drain();

        // Signed sums and two's complement wrap.
        push_exp(32'hFFFF_FFF6, 2, 1'b0);
        beat(-5); beat(3); beat(-1); beat(-7);
        push_exp(32'h8000_0000, 3, 1'b1);
        beat(32'h7FFF_FFFF); beat(1); beat(0); beat(0);
        wait_drain();

        // Row indexing across a wrap of the row counter.
        reset_dut();
        for (int r = 0; r < 5; r++) begin
            push_exp(32'd4, r % 4, (r % 4) == 3);
            beat(1); beat(1); beat(1); beat(1);
        end
        wait_drain();

        // Overflow: fifth row dropped while the FIFO is full and stalled.
        reset_dut();
        oready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) push_exp(32'(10 * i), i - 1, i == 4);
            beat(i); beat(2 * i); beat(3 * i); beat(4 * i);
        end
        @(negedge clk);
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_ovalid", ovalid, 1);
        @(posedge clk); #1;
        oready = 1'b1;
        wait_drain();
        push_exp(32'd60, 1, 1'b0);
        beat(6); beat(12); beat(18); beat(24);
        wait_drain();
        @(negedge clk);
        check("ovf_sticky", overflow, 1);
        @(posedge clk); #1;

        // Full FIFO with a pop on the completing cycle keeps the new row.
        reset_dut();
        oready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_exp(32'(10 * i), i - 1, i == 4);
            beat(i); beat(2 * i); beat(3 * i); beat(4 * i);
        end
        push_exp(32'd50, 0, 1'b0);
        beat(5); beat(10); beat(15);
        ivalid = 1'b1;
        idata  = 32'd20;
        oready = 1'b1;
        @(posedge clk); #1;
        ivalid = 1'b0;
        oready = 1'b0;
        @(negedge clk);
        check("fullpop_count", count, 4);
        check("fullpop_overflow", overflow, 0);
        @(posedge clk); #1;
        oready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("fullpop_empty", count, 0);
        @(posedge clk); #1;

        // Reset in the middle of a row discards the partial sum.
        beat(9); beat(9);
        reset_dut();
        push_exp(32'd4, 0, 1'b0);
        beat(1); beat(1); beat(1); beat(1);
        @(negedge clk);
        check("midrst_overflow", overflow, 0);
        check("midrst_count", count, 1);
        @(posedge clk); #1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
